// File: rtl/disp_window_driver.sv
// disp_window_driver
// Display scan-out engine. Generates raster timing from pixel_clock, pulls source
// pixels from a show-ahead read FIFO and places them in a runtime-positioned window
// inside the visible area. Pixels outside the window show border_rgb. Supports 1x
// and 2x integer upscale; 2x odd rows are replayed from an internal line buffer.
//
// Ports:
//   pixel_clock   in   sole clock
//   reset         in   asynchronous, active-low
//   ext_sync      in   synchronous frame restart (counters to 0 on next clock)
//   win_x, win_y  in   window top-left in visible coordinates (latched per frame)
//   scale2x       in   0 = 1x, 1 = 2x (latched per frame)
//   border_rgb    in   colour for visible pixels outside the window
//   rd_clk        out  FIFO read clock (= pixel_clock)
//   rd_load       out  high during vsync lines; frame source rewinds on it
//   rdfifo_rden   out  FIFO read enable (combinational from the counters)
//   rdfifo_dout   in   FIFO data, RGB in the top 24 bits
//   rdfifo_empty  in   FIFO empty
//   video_*       out  registered video timing and pixel, 1 clock behind counters
//   underflow     out  set on a read from an empty FIFO, cleared at frame start
//   underflow_cnt out  saturating count of underflowed pixels, cleared by reset only
module disp_window_driver #(
  parameter int unsigned SRC_H   = 800,
  parameter int unsigned SRC_V   = 480,
  parameter int unsigned FIFO_W  = 32,
  parameter int unsigned H_TOTAL = 2200,
  parameter int unsigned H_SYNC  = 44,
  parameter int unsigned H_BP    = 148,
  parameter int unsigned H_VIS   = 1920,
  parameter int unsigned V_TOTAL = 1125,
  parameter int unsigned V_SYNC  = 5,
  parameter int unsigned V_BP    = 36,
  parameter int unsigned V_VIS   = 1080,
  parameter bit          HS_POL  = 1'b1,
  parameter bit          VS_POL  = 1'b1
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              ext_sync,
  input  logic [13:0]       win_x,
  input  logic [13:0]       win_y,
  input  logic              scale2x,
  input  logic [23:0]       border_rgb,
  output logic              rd_clk,
  output logic              rd_load,
  output logic              rdfifo_rden,
  input  logic [FIFO_W-1:0] rdfifo_dout,
  input  logic              rdfifo_empty,
  output logic              video_vsync,
  output logic              video_hsync,
  output logic              video_den,
  output logic [23:0]       video_pixel,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam logic [15:0] HLast    = 16'(H_TOTAL - 1);
  localparam logic [15:0] VLast    = 16'(V_TOTAL - 1);
  localparam logic [15:0] HSyncEnd = 16'(H_SYNC);
  localparam logic [15:0] VSyncEnd = 16'(V_SYNC);
  localparam logic [15:0] HVisBeg  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] HVisEnd  = 16'(H_SYNC + H_BP + H_VIS);
  localparam logic [15:0] VVisBeg  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] VVisEnd  = 16'(V_SYNC + V_BP + V_VIS);
  localparam logic [15:0] HVisLen  = 16'(H_VIS);
  localparam logic [15:0] VVisLen  = 16'(V_VIS);
  localparam logic [15:0] SrcW1    = 16'(SRC_H);
  localparam logic [15:0] SrcW2    = 16'(2 * SRC_H);
  localparam logic [15:0] SrcH1    = 16'(SRC_V);
  localparam logic [15:0] SrcH2    = 16'(2 * SRC_V);
  localparam int unsigned LbAw     = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  // Raster counters
  logic [15:0] r_h_cnt, r_v_cnt;
  logic [15:0] w_h_nxt, w_v_nxt;
  logic        w_frame_start;

  // Per-frame latched window
  logic [15:0] r_wx, r_wy;
  logic        r_s2x;
  logic [15:0] w_new_w, w_new_h, w_max_x, w_max_y, w_req_x, w_req_y;

  // Datapath
  logic              w_vis, w_in_win, w_odd_row, w_odd_col, w_underrun;
  logic [15:0]       w_px, w_py, w_dx, w_dy, w_win_w, w_win_h;
  logic [23:0]       w_fetch_rgb, w_pix_nxt;
  logic [LbAw-1:0]   w_lb_waddr, w_lb_raddr;
  logic [23:0]       r_lbuf [SRC_H];
  logic [23:0]       r_lb_q;

  // Output registers
  logic        r_hs, r_vs, r_den, r_load, r_uf;
  logic [23:0] r_pix;
  logic [15:0] r_uf_cnt;

  assign rd_clk = pixel_clock;

  if (FIFO_W > 24) begin : g_unused_low
    logic w_unused_low;
    assign w_unused_low = ^rdfifo_dout[FIFO_W-25:0];
  end

  // ---------------------------------------------------------------------------
  // Counters; ext_sync overrides the normal wrap.
  always_comb begin
    w_h_nxt = r_h_cnt + 16'd1;
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == HLast) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v_cnt == VLast) ? '0 : r_v_cnt + 16'd1;
    end
    if (ext_sync) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end
  end

  assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Window latch: sampled during the frame-start cycle, clamped so the whole
  // window stays inside the visible area.
  always_comb begin
    w_new_w = scale2x ? SrcW2 : SrcW1;
    w_new_h = scale2x ? SrcH2 : SrcH1;
    w_max_x = HVisLen - w_new_w;
    w_max_y = VVisLen - w_new_h;
    w_req_x = {2'b00, win_x};
    w_req_y = {2'b00, win_y};
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_wx  <= '0;
      r_wy  <= '0;
      r_s2x <= 1'b0;
    end else if (w_frame_start) begin
      r_wx  <= (w_req_x > w_max_x) ? w_max_x : w_req_x;
      r_wy  <= (w_req_y > w_max_y) ? w_max_y : w_req_y;
      r_s2x <= scale2x;
    end
  end

  // ---------------------------------------------------------------------------
  // Window decode and pixel select. Window offsets use wrap-around subtraction,
  // so positions left of / above the window compare as large and fall outside.
  always_comb begin
    w_vis      = (r_h_cnt >= HVisBeg) && (r_h_cnt < HVisEnd) &&
                 (r_v_cnt >= VVisBeg) && (r_v_cnt < VVisEnd);
    w_px       = r_h_cnt - HVisBeg;
    w_py       = r_v_cnt - VVisBeg;
    w_dx       = w_px - r_wx;
    w_dy       = w_py - r_wy;
    w_win_w    = r_s2x ? SrcW2 : SrcW1;
    w_win_h    = r_s2x ? SrcH2 : SrcH1;
    w_in_win   = w_vis && (w_dx < w_win_w) && (w_dy < w_win_h);
    w_odd_row  = r_s2x & w_dy[0];
    w_odd_col  = r_s2x & w_dx[0];
    rdfifo_rden = w_in_win & ~w_odd_row & ~w_odd_col;
    w_underrun  = rdfifo_rden & rdfifo_empty;
    w_fetch_rgb = rdfifo_empty ? 24'h000000 : rdfifo_dout[FIFO_W-1 -: 24];
    // Read address runs one column ahead so r_lb_q holds this column's pixel
    // by the time the output register samples it.
    w_lb_waddr  = LbAw'(w_dx >> 1);
    w_lb_raddr  = LbAw'((w_dx + 16'd1) >> 1);

    w_pix_nxt = 24'h000000;
    if (w_vis) begin
      if (!w_in_win)     w_pix_nxt = border_rgb;
      else if (w_odd_row) w_pix_nxt = r_lb_q;
      else if (w_odd_col) w_pix_nxt = r_pix;   // second copy of the fetched pixel
      else               w_pix_nxt = w_fetch_rgb;
    end
  end

  // Line buffer: written on 2x even-row fetches, read continuously.
  always_ff @(posedge pixel_clock) begin
    if (rdfifo_rden && r_s2x) begin
      r_lbuf[w_lb_waddr] <= w_fetch_rgb;
    end
    r_lb_q <= r_lbuf[w_lb_raddr];
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_hs     <= ~HS_POL;
      r_vs     <= ~VS_POL;
      r_den    <= 1'b0;
      r_load   <= 1'b0;
      r_pix    <= '0;
      r_uf     <= 1'b0;
      r_uf_cnt <= '0;
    end else begin
      r_hs   <= (r_h_cnt < HSyncEnd) ? HS_POL : ~HS_POL;
      r_vs   <= (r_v_cnt < VSyncEnd) ? VS_POL : ~VS_POL;
      r_den  <= w_vis;
      r_load <= (r_v_cnt < VSyncEnd);
      r_pix  <= w_pix_nxt;
      if (w_underrun) begin
        r_uf <= 1'b1;
      end else if (w_frame_start) begin
        r_uf <= 1'b0;
      end
      if (w_underrun && (r_uf_cnt != 16'hFFFF)) begin
        r_uf_cnt <= r_uf_cnt + 16'd1;
      end
    end
  end

  assign video_hsync   = r_hs;
  assign video_vsync   = r_vs;
  assign video_den     = r_den;
  assign video_pixel   = r_pix;
  assign rd_load       = r_load;
  assign underflow     = r_uf;
  assign underflow_cnt = r_uf_cnt;

endmodule

// File: tb/tb_disp_window_driver.sv
// Testbench for disp_window_driver with a small raster (20x12 total, 12x8
// visible) and a 4x3 source. An environment FIFO counts up from 1 and rewinds
// on rd_load. A reference model tracks the raster, pushes the expected
// registered outputs of each cycle to a scoreboard queue, and pops/compares
// them one clock later.
`timescale 1ns/1ps
module tb_disp_window_driver;

  localparam int SRC_H = 4, SRC_V = 3, FIFO_W = 32;
  localparam int H_TOTAL = 20, H_SYNC = 2, H_BP = 2, H_VIS = 12;
  localparam int V_TOTAL = 12, V_SYNC = 1, V_BP = 1, V_VIS = 8;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam logic [23:0] BORDER = 24'hABCDEF;

  logic              pixel_clock = 1'b0;
  logic              reset;
  logic              ext_sync;
  logic [13:0]       win_x, win_y;
  logic              scale2x;
  logic [23:0]       border_rgb;
  logic              rd_clk, rd_load, rdfifo_rden;
  logic [FIFO_W-1:0] rdfifo_dout;
  logic              rdfifo_empty;
  logic              video_vsync, video_hsync, video_den;
  logic [23:0]       video_pixel;
  logic              underflow;
  logic [15:0]       underflow_cnt;

  always #5 pixel_clock = ~pixel_clock;

  disp_window_driver #(
    .SRC_H(SRC_H), .SRC_V(SRC_V), .FIFO_W(FIFO_W),
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_VIS(H_VIS),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_VIS(V_VIS),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .ext_sync     (ext_sync),
    .win_x        (win_x),
    .win_y        (win_y),
    .scale2x      (scale2x),
    .border_rgb   (border_rgb),
    .rd_clk       (rd_clk),
    .rd_load      (rd_load),
    .rdfifo_rden  (rdfifo_rden),
    .rdfifo_dout  (rdfifo_dout),
    .rdfifo_empty (rdfifo_empty),
    .video_vsync  (video_vsync),
    .video_hsync  (video_hsync),
    .video_den    (video_den),
    .video_pixel  (video_pixel),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt)
  );

  // Environment FIFO: counts 1,2,3,... per successful read, rewinds on rd_load.
  logic [23:0] fifo_val;
  assign rdfifo_dout = {fifo_val, 8'h5A};
  always @(posedge pixel_clock or negedge reset) begin
    if (!reset)                            fifo_val <= 24'd1;
    else if (rd_load)                      fifo_val <= 24'd1;
    else if (rdfifo_rden && !rdfifo_empty) fifo_val <= fifo_val + 24'd1;
  end

  typedef struct {
    int          h;
    int          v;
    logic [23:0] pix;
    logic [4:0]  ctl;   // {den, hsync, vsync, rd_load, underflow}
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0, n_fail = 0;
  int   m_h, m_v, m_wx, m_wy, m_cnt;
  bit   m_s, m_uf;
  int   frame_reads, load_seen;
  bit   uf_mode;
  int   uf_v, uf_h;

  // One raster cycle: model it, push expectation, check rden, pop and check outputs.
  task automatic step();
    exp_t e;
    int   px, py, dx, dy, ww, wh;
    bit   vis, inwin, rd;
    if (m_h == 0 && m_v == 0) begin
      m_s  = scale2x;
      ww   = m_s ? 2 * SRC_H : SRC_H;
      wh   = m_s ? 2 * SRC_V : SRC_V;
      m_wx = (int'(win_x) > H_VIS - ww) ? H_VIS - ww : int'(win_x);
      m_wy = (int'(win_y) > V_VIS - wh) ? V_VIS - wh : int'(win_y);
      m_cnt = 1;
    end
    rdfifo_empty = uf_mode && (m_v == uf_v) && (m_h >= uf_h) && (m_h < uf_h + 3);
    ww    = m_s ? 2 * SRC_H : SRC_H;
    wh    = m_s ? 2 * SRC_V : SRC_V;
    vis   = (m_h >= H_SYNC + H_BP) && (m_h < H_SYNC + H_BP + H_VIS) &&
            (m_v >= V_SYNC + V_BP) && (m_v < V_SYNC + V_BP + V_VIS);
    px    = m_h - (H_SYNC + H_BP);
    py    = m_v - (V_SYNC + V_BP);
    dx    = px - m_wx;
    dy    = py - m_wy;
    inwin = vis && dx >= 0 && dx < ww && dy >= 0 && dy < wh;
    rd    = inwin && (!m_s || (dy % 2 == 0 && dx % 2 == 0));
    e.h = m_h;
    e.v = m_v;
    if (!vis)        e.pix = 24'h0;
    else if (!inwin) e.pix = BORDER;
    else if (m_s)    e.pix = 24'(1 + (dy / 2) * SRC_H + dx / 2);
    else             e.pix = rdfifo_empty ? 24'h0 : 24'(m_cnt);
    if (rd && !rdfifo_empty) m_cnt++;
    if (rd && rdfifo_empty) m_uf = 1'b1;
    else if (m_h == 0 && m_v == 0) m_uf = 1'b0;
    e.ctl = {vis, m_h < H_SYNC, m_v < V_SYNC, m_v < V_SYNC, m_uf};
    sb_q.push_back(e);

    @(negedge pixel_clock);
    n_tests++;
    if (rdfifo_rden !== rd) begin
      n_fail++;
      $display("FAIL rden (h=%0d,v=%0d) got %b want %b", m_h, m_v, rdfifo_rden, rd);
    end
    if (rdfifo_rden === 1'b1) frame_reads++;

    @(posedge pixel_clock);
    #1;
    e = sb_q.pop_front();
    if (rd_load === 1'b1) load_seen++;
    n_tests++;
    if (video_pixel !== e.pix) begin
      n_fail++;
      $display("FAIL pixel (h=%0d,v=%0d) got %06h want %06h", e.h, e.v, video_pixel, e.pix);
    end
    n_tests++;
    if ({video_den, video_hsync, video_vsync, rd_load, underflow} !== e.ctl) begin
      n_fail++;
      $display("FAIL ctl (h=%0d,v=%0d) got %b want %b", e.h, e.v,
               {video_den, video_hsync, video_vsync, rd_load, underflow}, e.ctl);
    end

    if (ext_sync) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == H_TOTAL - 1) begin
      m_h = 0;
      m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  task automatic run_frame();
    frame_reads = 0;
    load_seen   = 0;
    repeat (FRAME) step();
  endtask

  task automatic check_reads(string name, int want);
    n_tests++;
    if (frame_reads !== want) begin
      n_fail++;
      $display("FAIL %s reads got %0d want %0d", name, frame_reads, want);
    end
  endtask

  task automatic test_reset();
    @(posedge pixel_clock);
    #1;
    n_tests++;
    if ({video_den, video_hsync, video_vsync, rd_load, underflow, rdfifo_rden} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 000000",
               {video_den, video_hsync, video_vsync, rd_load, underflow, rdfifo_rden});
    end
    n_tests++;
    if (video_pixel !== 24'h0 || underflow_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data got pix=%06h cnt=%0d want 0/0", video_pixel, underflow_cnt);
    end
  endtask

  task automatic test_1x();
    win_x = 14'd2; win_y = 14'd1; scale2x = 1'b0;
    @(posedge pixel_clock);
    #1;
    reset = 1'b1;
    m_h = 0; m_v = 0; m_uf = 1'b0;
    run_frame();
    check_reads("1x", SRC_H * SRC_V);
  endtask

  task automatic test_2x();
    win_x = 14'd0; win_y = 14'd0; scale2x = 1'b1;
    run_frame();
    check_reads("2x", SRC_H * SRC_V);
  endtask

  task automatic test_clamp();
    win_x = 14'd11; win_y = 14'd1; scale2x = 1'b0;
    run_frame();
    check_reads("clamp", SRC_H * SRC_V);
  endtask

  task automatic test_underflow();
    win_x = 14'd2; win_y = 14'd1; scale2x = 1'b0;
    uf_mode = 1'b1;
    uf_v = V_SYNC + V_BP + 1 + 1;  // window row 1
    uf_h = H_SYNC + H_BP + 2;      // window columns 0..2
    run_frame();
    uf_mode = 1'b0;
    n_tests++;
    if (underflow_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL uf_cnt got %0d want 3", underflow_cnt);
    end
    run_frame();
    n_tests++;
    if (underflow !== 1'b0 || underflow_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL uf_clear got uf=%b cnt=%0d want 0/3", underflow, underflow_cnt);
    end
  endtask

  task automatic test_ext_sync();
    win_x = 14'd2; win_y = 14'd1; scale2x = 1'b0;
    repeat (3 * H_TOTAL + 7) step();  // stop mid-window, line 3
    win_x = 14'd5;
    ext_sync = 1'b1;
    step();
    ext_sync = 1'b0;
    run_frame();
    check_reads("ext_sync", SRC_H * SRC_V);
    n_tests++;
    if (load_seen !== H_TOTAL * V_SYNC) begin
      n_fail++;
      $display("FAIL rd_load_len got %0d want %0d", load_seen, H_TOTAL * V_SYNC);
    end
  endtask

  task automatic test_reset_mid();
    win_x = 14'd2; win_y = 14'd1; scale2x = 1'b0;
    repeat (4 * H_TOTAL + 8) step();  // inside the window, rden active
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({video_den, video_hsync, video_vsync, rd_load, underflow, rdfifo_rden} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_ctl got %b want 000000",
               {video_den, video_hsync, video_vsync, rd_load, underflow, rdfifo_rden});
    end
    n_tests++;
    if (video_pixel !== 24'h0 || underflow_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_data got pix=%06h cnt=%0d want 0/0", video_pixel, underflow_cnt);
    end
    @(posedge pixel_clock);
    #1;
    reset = 1'b1;
    sb_q.delete();
    m_h = 0; m_v = 0; m_uf = 1'b0;
    run_frame();
    check_reads("after_reset", SRC_H * SRC_V);
  endtask

  initial begin
    reset = 1'b0;
    ext_sync = 1'b0;
    win_x = 14'd0;
    win_y = 14'd0;
    scale2x = 1'b0;
    border_rgb = BORDER;
    rdfifo_empty = 1'b0;
    uf_mode = 1'b0;
    uf_v = 0;
    uf_h = 0;
    repeat (3) @(posedge pixel_clock);
    test_reset();
    test_1x();
    test_2x();
    test_clamp();
    test_underflow();
    test_ext_sync();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
